bus_arbiter: RTL and testbench

- Round-robin arbiter for the shared 32-bit datapath bus; generates the one-hot source select that steers the bus multiplexer.
- Six sources request the bus. The arbiter grants exactly one of them, holds that grant across a multi-cycle transfer, and enforces a hold limit. A one-cycle turnaround is inserted between owners.
- Sits directly upstream of the bus multiplexer's 6-bit select input.

---
 rtl/bus_arbiter.sv | 108 ++++++++++
 tb/tb_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter producing the one-hot select for the shared
// 32-bit datapath bus multiplexer. One owner at a time. A grant is held across
// a multi-cycle transfer and is subject to a hold limit. At least one idle
// (turnaround) cycle separates any two grants.
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-high reset
//   req         - per-source level request, held for the whole transfer
//   lock        - exempts the current owner from the hold limit
//   bSel        - registered one-hot bus select, all-zero when idle
//   grant_valid - registered, high exactly when bSel is non-zero
//   owner       - registered index of the current/last owner
module bus_arbiter #(
  parameter int N_SRC    = 6,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic             lock,
  output logic [N_SRC-1:0] bSel,
  output logic             grant_valid,
  output logic [CNT_W-1:0] owner
);

  localparam int SW = CNT_W + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] LAST_SRC  = CNT_W'(N_SRC - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [CNT_W-1:0] ptr;
  logic [CNT_W-1:0] hcnt;

  logic [CNT_W-1:0] win;
  logic             found;
  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] cand;
  logic             others_wait;
  logic             release_now;

  // Rotating first-one search starting at ptr, wrapping modulo N_SRC.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N_SRC)) sum = sum - SW'(N_SRC);
      cand = sum[CNT_W-1:0];
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // In GRANT, bSel is the owner's one-hot, so masking it out leaves the waiters.
  assign others_wait = |(req & ~bSel);
  assign release_now = !req[owner] ||
                       ((hcnt == HOLD_LAST) && !lock && others_wait);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bSel        <= '0;
      grant_valid <= 1'b0;
      owner       <= '0;
      ptr         <= '0;
      hcnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            bSel        <= N_SRC'(1) << win;
            owner       <= win;
            grant_valid <= 1'b1;
            hcnt        <= '0;
            state       <= GRANT;
          end else begin
            bSel        <= '0;
            grant_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            bSel        <= '0;
            grant_valid <= 1'b0;
            state       <= IDLE;
            ptr         <= (owner == LAST_SRC) ? '0 : owner + 1'b1;
          end else if (hcnt != HOLD_LAST) begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          bSel        <= '0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point
// (after the edge has settled) or on the falling edge in the random run.
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [5:0] req;
  logic       lock;
  logic [5:0] bSel;
  logic       grant_valid;
  logic [2:0] owner;

  int checks;
  int errors;

  bus_arbiter #(.N_SRC(6), .MAX_HOLD(8), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .lock        (lock),
    .bSel        (bSel),
    .grant_valid (grant_valid),
    .owner       (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req  = '0;
    lock = 1'b0;
    rst  = 1'b1;
    step();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    req  = 6'b111111;
    lock = 1'b0;
    rst  = 1'b1;
    #1;
    checks++;
    if (bSel !== 6'b000000 || grant_valid !== 1'b0 || owner !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: bSel=%b gv=%b owner=%0d, want 000000 0 0", bSel, grant_valid, owner);
    end
    step();
    step();
    checks++;
    if (bSel !== 6'b000000) begin
      errors++;
      $display("FAIL reset_held: bSel=%b, want 000000", bSel);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bSel !== 6'b000001 || grant_valid !== 1'b1 || owner !== 3'd0) begin
      errors++;
      $display("FAIL reset_first_grant: bSel=%b gv=%b owner=%0d, want 000001 1 0", bSel, grant_valid, owner);
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_sel [7];
    logic [2:0] exp_own [7];
    logic [5:0] drv     [7];
    exp_sel = '{6'b000001, 6'b000000, 6'b000100, 6'b000000, 6'b100000, 6'b000000, 6'b000001};
    exp_own = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 3'd0};
    // Request pattern applied after each sampled edge: owner drops, then re-raises.
    drv     = '{6'b100100, 6'b100101, 6'b100001, 6'b100101, 6'b000101, 6'b100101, 6'b100101};
    apply_reset();
    req = 6'b100101;
    for (int k = 0; k < 7; k++) begin
      step();
      checks++;
      if (bSel !== exp_sel[k] || owner !== exp_own[k] || grant_valid !== (exp_sel[k] != 0)) begin
        errors++;
        $display("FAIL round_robin[%0d]: bSel=%b owner=%0d gv=%b, want %b %0d %b",
                 k, bSel, owner, grant_valid, exp_sel[k], exp_own[k], exp_sel[k] != 0);
      end
      req = drv[k];
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 6'b000011;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (bSel !== 6'b000001 || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL timeout_hold[%0d]: bSel=%b gv=%b, want 000001 1", k, bSel, grant_valid);
      end
    end
    step();
    checks++;
    if (bSel !== 6'b000000 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release: bSel=%b gv=%b, want 000000 0", bSel, grant_valid);
    end
    step();
    checks++;
    if (bSel !== 6'b000010 || owner !== 3'd1) begin
      errors++;
      $display("FAIL timeout_next: bSel=%b owner=%0d, want 000010 1", bSel, owner);
    end
  endtask

  task automatic test_lock();
    int bad;
    apply_reset();
    lock = 1'b1;
    req  = 6'b000011;
    bad  = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bSel !== 6'b000001) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lock_hold: %0d of 20 cycles lost grant, want 0 (last bSel=%b)", bad, bSel);
    end
    lock = 1'b0;
    step();
    checks++;
    if (bSel !== 6'b000000) begin
      errors++;
      $display("FAIL lock_release: bSel=%b, want 000000", bSel);
    end
    step();
    checks++;
    if (bSel !== 6'b000010 || owner !== 3'd1) begin
      errors++;
      $display("FAIL lock_next: bSel=%b owner=%0d, want 000010 1", bSel, owner);
    end
  endtask

  task automatic test_sole_requester();
    int bad;
    apply_reset();
    req = 6'b001000;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bSel !== 6'b001000 || owner !== 3'd3) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sole_hold: %0d of 30 cycles wrong, want 0 (last bSel=%b)", bad, bSel);
    end
    checks++;
    if (dut.hcnt !== 3'd7) begin
      errors++;
      $display("FAIL sole_hcnt_sat: hcnt=%0d, want 7", dut.hcnt);
    end
    req = 6'b001010;
    step();
    checks++;
    if (bSel !== 6'b000000) begin
      errors++;
      $display("FAIL sole_release: bSel=%b, want 000000", bSel);
    end
    step();
    checks++;
    if (bSel !== 6'b000010 || owner !== 3'd1) begin
      errors++;
      $display("FAIL sole_next: bSel=%b owner=%0d, want 000010 1", bSel, owner);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 6'b000100;
    step();
    checks++;
    if (bSel !== 6'b000100 || owner !== 3'd2) begin
      errors++;
      $display("FAIL async_pre: bSel=%b owner=%0d, want 000100 2", bSel, owner);
    end
    lock = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bSel !== 6'b000000 || grant_valid !== 1'b0 || owner !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: bSel=%b gv=%b owner=%0d, want 000000 0 0", bSel, grant_valid, owner);
    end
    #1;
    rst  = 1'b0;
    lock = 1'b0;
    step();
    checks++;
    if (bSel !== 6'b000100 || owner !== 3'd2) begin
      errors++;
      $display("FAIL async_regrant: bSel=%b owner=%0d, want 000100 2", bSel, owner);
    end
  endtask

  task automatic test_invariant_random();
    int bad_pop;
    int bad_gv;
    int bad_own;
    apply_reset();
    bad_pop = 0;
    bad_gv  = 0;
    bad_own = 0;
    for (int k = 0; k < 10000; k++) begin
      req  = 6'($urandom_range(0, 63));
      lock = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      checks++;
      if ($countones(bSel) > 1) begin
        errors++;
        bad_pop++;
        if (bad_pop <= 5) $display("FAIL inv_onehot[%0d]: bSel=%b, want popcount<=1", k, bSel);
      end
      checks++;
      if (grant_valid !== (|bSel)) begin
        errors++;
        bad_gv++;
        if (bad_gv <= 5) $display("FAIL inv_gv[%0d]: gv=%b bSel=%b, want gv=%b", k, grant_valid, bSel, |bSel);
      end
      if (grant_valid === 1'b1) begin
        checks++;
        if (bSel !== (6'b000001 << owner)) begin
          errors++;
          bad_own++;
          if (bad_own <= 5) $display("FAIL inv_owner[%0d]: bSel=%b owner=%0d, want bSel=1<<owner", k, bSel, owner);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = '0;
    lock   = 1'b0;
    #2;
    test_reset();
    test_round_robin();
    test_timeout();
    test_lock();
    test_sole_requester();
    test_async_reset();
    test_invariant_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
